game_round_sequencer: RTL and testbench

GAME_ROUND_SEQUENCER -- requirements
Module: game_round_sequencer

---
 rtl/game_round_sequencer.sv | 172 +++++++++++++++++
 tb/tb_game_round_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_sequencer.sv
// Memory-game round sequencer: builds a growing random pattern, shows it on
// a one-hot LED bank, then checks the player's presses against it with an
// inter-press timeout.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for start; level/score hold the last game's values
//   APPEND   | append rnd to the pattern, grow level, rewind replay
//   SHOW_ON  | LED lit with pattern[idx] for ON_CYCLES cycles
//   SHOW_OFF | LED dark for OFF_CYCLES cycles, then next symbol or INPUT
//   INPUT    | compare presses with pattern[idx], idle timeout running
//   PASS     | round matched: pulse round_pass, bump score
//   FAIL     | mismatch or timeout: pulse round_fail
//   WIN      | full-length round matched: pulse win
module game_round_sequencer #(
    parameter int MAX_LEN        = 25,
    parameter int ON_CYCLES      = 4,
    parameter int OFF_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] rnd,
    input  logic       btn_valid,
    input  logic [2:0] btn,
    output logic [7:0] led,
    output logic       busy,
    output logic       awaiting_input,
    output logic       round_pass,
    output logic       round_fail,
    output logic       win,
    output logic [4:0] level,
    output logic [7:0] score
);

    localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX0  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMAX   = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPEND,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_INPUT,
        ST_PASS,
        ST_FAIL,
        ST_WIN
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    level_nxt;
    logic [7:0]    score_nxt;
    logic [4:0]    idx, idx_nxt, idx_inc;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    pattern [MAX_LEN];
    logic [2:0]    cur_sym;

    assign cur_sym = pattern[idx[IW-1:0]];

    // Pattern storage has no reset; only symbols below level are ever read.
    always_ff @(posedge clk) begin
        if (state == ST_APPEND && level < LEN_MAX) begin
            pattern[level[IW-1:0]] <= rnd;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            level <= 5'd0;
            score <= 8'd0;
            idx   <= 5'd0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            score <= score_nxt;
            idx   <= idx_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        score_nxt = score;
        idx_nxt   = idx;
        timer_nxt = timer;
        idx_inc   = idx + 5'd1;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    level_nxt = 5'd0;
                    score_nxt = 8'd0;
                    state_nxt = ST_APPEND;
                end
            end
            ST_APPEND: begin
                level_nxt = level + 5'd1;
                idx_nxt   = 5'd0;
                timer_nxt = '0;
                state_nxt = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (timer == ON_LAST) begin
                    timer_nxt = '0;
                    state_nxt = ST_SHOW_OFF;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_SHOW_OFF: begin
                if (timer == OFF_LAST) begin
                    timer_nxt = '0;
                    if (idx_inc == level) begin
                        idx_nxt   = 5'd0;
                        state_nxt = ST_INPUT;
                    end else begin
                        idx_nxt   = idx_inc;
                        state_nxt = ST_SHOW_ON;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_INPUT: begin
                // A press in the same cycle as the timeout wins over it.
                if (btn_valid) begin
                    if (btn != cur_sym) begin
                        state_nxt = ST_FAIL;
                    end else if (idx == level - 5'd1) begin
                        state_nxt = ST_PASS;
                    end else begin
                        idx_nxt   = idx_inc;
                        timer_nxt = '0;
                    end
                end else if (timer == TO_LAST) begin
                    state_nxt = ST_FAIL;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_PASS: begin
                if (score != 8'hFF) begin
                    score_nxt = score + 8'd1;
                end
                state_nxt = (level == LEN_MAX) ? ST_WIN : ST_APPEND;
            end
            ST_FAIL: state_nxt = ST_IDLE;
            ST_WIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign led            = (state == ST_SHOW_ON) ? (8'b1 << cur_sym) : 8'b0;
    assign busy           = (state != ST_IDLE);
    assign awaiting_input = (state == ST_INPUT);
    assign round_pass     = (state == ST_PASS);
    assign round_fail     = (state == ST_FAIL);
    assign win            = (state == ST_WIN);

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer with MAX_LEN=3, ON=4, OFF=2, TIMEOUT=64.
module tb_game_round_sequencer;

    localparam int MAX_LEN = 3;
    localparam int ON_C    = 4;
    localparam int OFF_C   = 2;
    localparam int TO_C    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_r = 1'b0;
    logic [2:0] rnd_r = 3'd0;
    logic       bv_r = 1'b0;
    logic [2:0] btn_r = 3'd0;
    logic [7:0] led;
    logic       busy, awaiting_input, round_pass, round_fail, win;
    logic [4:0] level;
    logic [7:0] score;

    game_round_sequencer #(
        .MAX_LEN(MAX_LEN), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .clk(clk), .rst(rst), .start(start_r), .rnd(rnd_r),
        .btn_valid(bv_r), .btn(btn_r), .led(led), .busy(busy),
        .awaiting_input(awaiting_input), .round_pass(round_pass),
        .round_fail(round_fail), .win(win), .level(level), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] led;
        logic       busy;
        logic       aw;
        logic       pass;
        logic       fail;
        logic       win;
        logic [4:0] level;
        logic [7:0] score;
    } snap_t;

    typedef struct {
        bit         new_game;
        bit         hold;
        bit         noise;
        logic [2:0] rnd;
        int         npress;
        logic [2:0] press [3];
    } round_t;

    snap_t      sb_q [$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_level = 5'd0;
    logic [7:0] exp_score = 8'd0;
    logic [2:0] pat [MAX_LEN];
    round_t     rounds [8];

    function automatic snap_t mk(input logic [7:0] l, input logic b, input logic a,
                                 input logic p, input logic f, input logic w);
        snap_t s;
        s.led = l; s.busy = b; s.aw = a; s.pass = p; s.fail = f; s.win = w;
        s.level = exp_level; s.score = exp_score;
        return s;
    endfunction

    function automatic round_t mk_round(input bit nw, input bit hold, input bit noise,
                                        input logic [2:0] r, input int np,
                                        input logic [2:0] p0, input logic [2:0] p1,
                                        input logic [2:0] p2);
        round_t t;
        t.new_game = nw; t.hold = hold; t.noise = noise; t.rnd = r; t.npress = np;
        t.press[0] = p0; t.press[1] = p1; t.press[2] = p2;
        return t;
    endfunction

    task automatic compare(input string name);
        snap_t g, x;
        g = {led, busy, awaiting_input, round_pass, round_fail, win, level, score};
        x = sb_q.pop_front();
        checks++;
        if (g !== x) begin
            errors++;
            $display("FAIL %s @%0t: got led=%h busy=%b aw=%b pass=%b fail=%b win=%b level=%0d score=%0d; expected led=%h busy=%b aw=%b pass=%b fail=%b win=%b level=%0d score=%0d",
                     name, $time, g.led, g.busy, g.aw, g.pass, g.fail, g.win, g.level, g.score,
                     x.led, x.busy, x.aw, x.pass, x.fail, x.win, x.level, x.score);
        end
    endtask

    // One clock: expectation queued with the stimulus, checked after the edge.
    task automatic step(input string name, input snap_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic check_now(input string name, input snap_t e);
        sb_q.push_back(e);
        compare(name);
    endtask

    // From APPEND: replay the pattern and arrive in INPUT.
    task automatic show_round(input logic [2:0] r, input bit noise);
        rnd_r = r;
        pat[exp_level] = r;
        exp_level = exp_level + 5'd1;
        for (int s = 0; s < int'(exp_level); s++) begin
            for (int c = 0; c < ON_C; c++) begin
                if (noise) begin
                    bv_r  = 1'b1;
                    btn_r = 3'($urandom_range(0, 7));
                end
                step("show_on", mk(8'b1 << pat[s], 1, 0, 0, 0, 0));
            end
            bv_r = 1'b0;
            for (int c = 0; c < OFF_C; c++) step("show_off", mk(8'h00, 1, 0, 0, 0, 0));
        end
        step("enter_input", mk(8'h00, 1, 1, 0, 0, 0));
    endtask

    task automatic finish_in_idle(input string name);
        step(name, mk(8'h00, 0, 0, 0, 0, 0));
        start_r = 1'b0;
        step("idle_hold", mk(8'h00, 0, 0, 0, 0, 0));
    endtask

    task automatic run_round(input round_t r);
        if (r.new_game) begin
            start_r   = 1'b1;
            exp_level = 5'd0;
            exp_score = 8'd0;
            step("start_append", mk(8'h00, 1, 0, 0, 0, 0));
            if (!r.hold) start_r = 1'b0;
        end
        show_round(r.rnd, r.noise);
        for (int p = 0; p < r.npress; p++) begin
            bv_r  = 1'b1;
            btn_r = r.press[p];
            if (r.press[p] != pat[p]) begin
                step("press_wrong", mk(8'h00, 1, 0, 0, 1, 0));
                bv_r = 1'b0;
                finish_in_idle("fail_idle");
                return;
            end else if (p == int'(exp_level) - 1) begin
                step("press_last", mk(8'h00, 1, 0, 1, 0, 0));
                bv_r = 1'b0;
                if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
                if (int'(exp_level) == MAX_LEN) begin
                    step("win_pulse", mk(8'h00, 1, 0, 0, 0, 1));
                    finish_in_idle("win_idle");
                end else begin
                    step("next_append", mk(8'h00, 1, 0, 0, 0, 0));
                end
                return;
            end else begin
                step("press_ok", mk(8'h00, 1, 1, 0, 0, 0));
                bv_r = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected done before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rounds[0] = mk_round(1, 0, 0, 3'd5, 1, 3'd5, 3'd0, 3'd0);
        rounds[1] = mk_round(0, 0, 0, 3'd3, 2, 3'd5, 3'd2, 3'd0);
        rounds[2] = mk_round(1, 1, 1, 3'd1, 1, 3'd1, 3'd0, 3'd0);
        rounds[3] = mk_round(0, 1, 1, 3'd6, 2, 3'd1, 3'd6, 3'd0);
        rounds[4] = mk_round(0, 1, 1, 3'd2, 3, 3'd1, 3'd6, 3'd2);
        rounds[5] = mk_round(1, 0, 0, 3'd7, 1, 3'd0, 3'd0, 3'd0);
        rounds[6] = mk_round(1, 0, 0, 3'd0, 1, 3'd0, 3'd0, 3'd0);
        rounds[7] = mk_round(0, 0, 0, 3'd4, 1, 3'd4, 3'd0, 3'd0);

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 check_now("reset_async", mk(8'h00, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        step("idle_after_reset", mk(8'h00, 0, 0, 0, 0, 0));

        for (int i = 0; i < 8; i++) run_round(rounds[i]);

        // Timeout: a matching press in the last allowed cycle restarts the timer.
        run_round(mk_round(1, 0, 0, 3'd4, 1, 3'd4, 3'd0, 3'd0));
        show_round(3'd1, 0);
        for (int c = 1; c < TO_C; c++) step("wait_input", mk(8'h00, 1, 1, 0, 0, 0));
        bv_r  = 1'b1;
        btn_r = 3'd4;
        step("press_at_63", mk(8'h00, 1, 1, 0, 0, 0));
        bv_r = 1'b0;
        for (int c = 1; c < TO_C; c++) step("wait_input2", mk(8'h00, 1, 1, 0, 0, 0));
        step("timeout_fail", mk(8'h00, 1, 0, 0, 1, 0));
        finish_in_idle("timeout_idle");

        // Reset in the middle of SHOW_ON, then a fresh game.
        start_r   = 1'b1;
        exp_level = 5'd0;
        exp_score = 8'd0;
        step("start_append", mk(8'h00, 1, 0, 0, 0, 0));
        start_r = 1'b0;
        rnd_r   = 3'd3;
        exp_level = 5'd1;
        step("show_before_rst", mk(8'h08, 1, 0, 0, 0, 0));
        step("show_before_rst2", mk(8'h08, 1, 0, 0, 0, 0));
        #2 rst = 1'b1;
        exp_level = 5'd0;
        #1 check_now("reset_mid_show", mk(8'h00, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        step("idle_after_rst", mk(8'h00, 0, 0, 0, 0, 0));
        run_round(mk_round(1, 0, 0, 3'd2, 1, 3'd2, 3'd0, 3'd0));
        run_round(mk_round(0, 0, 0, 3'd6, 2, 3'd2, 3'd5, 3'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
